// File: rtl/pci_pkg.sv
// pci_pkg: shared definitions for the PCI initiator slice.
//   - PCI command encodings used by the initiator and its users
//   - initiator FSM state enum
//   - default AD bus width and a write-command helper
package pci_pkg;

    localparam int PCI_DATA_W = 32;

    localparam logic [3:0] IO_RD  = 4'b0010;
    localparam logic [3:0] IO_WR  = 4'b0011;
    localparam logic [3:0] MEM_RD = 4'b0110;
    localparam logic [3:0] MEM_WR = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_DATA,
        ST_TURN
    } initState_t;

    // Bit 0 of every PCI command selects write direction.
    function automatic logic isWrite(input logic [3:0] c);
        return c[0];
    endfunction

endpackage

// File: rtl/pci_phase_counter.sv
// pci_phase_counter: burst bookkeeping for the initiator.
//   remaining : data phases still to run, loaded from the request (0 loads as 1)
//   xferCnt   : data phases completed in the current/last transaction
// Ports: clk, rst (sync, active-high), load + loadLen, clear (zero xferCnt),
//        step (one phase completed), remaining, xferCnt, last (remaining==1),
//        zero (remaining==0).
// Neither counter wraps.
module pci_phase_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] loadLen,
    input  logic             clear,
    input  logic             step,
    output logic [LEN_W-1:0] remaining,
    output logic [LEN_W-1:0] xferCnt,
    output logic             last,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            xferCnt   <= '0;
        end else if (load) begin
            remaining <= (loadLen == '0) ? LEN_W'(1) : loadLen;
            xferCnt   <= '0;
        end else begin
            if (step && remaining != '0)
                remaining <= remaining - 1'b1;
            if (clear)
                xferCnt <= '0;
            else if (step && xferCnt != '1)
                xferCnt <= xferCnt + 1'b1;
        end
    end

    assign last = (remaining == LEN_W'(1));
    assign zero = (remaining == '0);

endmodule

// File: rtl/pci_initiator.sv
// pci_initiator: bus-master front end for one PCI agent.
//   Local side : start/cmd/addr/burst_len request, wr_data/wr_pop write stream,
//                rd_data/rd_valid read stream, busy/done/abort/xfer_cnt status.
//   Arbiter    : req_n out, gnt_n in.
//   Bus        : FRAME#/IRDY#/AD/C-BE# as _out/_oe (+ _in for idle detect and AD),
//                TRDY#/DEVSEL#/STOP# from the target.
// One address phase, then a 1..15 phase burst, a one-cycle turnaround, and a
// done (normal or target stop) or abort (no DEVSEL) pulse.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int DATA_W         = PCI_DATA_W,
    parameter int LEN_W          = 4,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [LEN_W-1:0]  xfer_cnt,
    output logic              req_n,
    input  logic              gnt_n,
    input  logic              frame_n_in,
    input  logic              irdy_n_in,
    output logic              frame_n_out,
    output logic              frame_oe,
    output logic              irdy_n_out,
    output logic              irdy_oe,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in,
    output logic [3:0]        cbe_n_out,
    output logic              cbe_oe,
    input  logic              trdy_n,
    input  logic              devsel_n,
    input  logic              stop_n
);

    localparam int DC_W = $clog2(DEVSEL_TIMEOUT + 1);

    initState_t        state;
    logic [3:0]        cmdLat;
    logic [DATA_W-1:0] addrLat;
    logic [DATA_W-1:0] adReg;
    logic              ending;      // FRAME# already released, IRDY# drops next edge
    logic              endAbort;
    logic              devselSeen;
    logic [DC_W-1:0]   devselCnt;
    logic [LEN_W-1:0]  remaining;
    logic              cntLast, cntZero;

    logic isWr, inData, phaseDone, devselTo, stopSeen, step;

    assign isWr      = isWrite(cmdLat);
    assign inData    = (state == ST_DATA) && !ending;
    assign phaseDone = inData && !irdy_n_out && !trdy_n;
    assign devselTo  = inData && devsel_n && !devselSeen &&
                       (devselCnt == DC_W'(DEVSEL_TIMEOUT - 1));
    assign stopSeen  = inData && !stop_n && !devselTo;
    assign step      = phaseDone && !devselTo && !cntZero;

    // The write word goes straight from the user's holding register onto AD, and
    // wr_pop fires in the completing cycle so the next word is there for the
    // following edge without inserting master wait states.
    assign ad_out = (state == ST_DATA && isWr) ? wr_data : adReg;
    assign wr_pop = step && isWr;

    pci_phase_counter #(.LEN_W(LEN_W)) u_phaseCnt (
        .clk       (clk),
        .rst       (rst),
        .load      (state == ST_IDLE && start),
        .loadLen   (burst_len),
        .clear     (devselTo),
        .step      (step),
        .remaining (remaining),
        .xferCnt   (xfer_cnt),
        .last      (cntLast),
        .zero      (cntZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmdLat      <= '0;
            addrLat     <= '0;
            adReg       <= '0;
            ending      <= 1'b0;
            endAbort    <= 1'b0;
            devselSeen  <= 1'b0;
            devselCnt   <= '0;
            req_n       <= 1'b1;
            frame_n_out <= 1'b1;
            frame_oe    <= 1'b0;
            irdy_n_out  <= 1'b1;
            irdy_oe     <= 1'b0;
            ad_oe       <= 1'b0;
            cbe_n_out   <= 4'hF;
            cbe_oe      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            abort       <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            done     <= 1'b0;
            abort    <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    cmdLat  <= cmd;
                    addrLat <= addr;
                    busy    <= 1'b1;
                    req_n   <= 1'b0;
                    state   <= ST_REQ;
                end
                ST_REQ: if (!gnt_n && frame_n_in && irdy_n_in) begin
                    state       <= ST_ADDR;
                    req_n       <= 1'b1;
                    frame_n_out <= 1'b0;
                    frame_oe    <= 1'b1;
                    irdy_n_out  <= 1'b1;
                    irdy_oe     <= 1'b1;
                    adReg       <= addrLat;
                    ad_oe       <= 1'b1;
                    cbe_n_out   <= cmdLat;
                    cbe_oe      <= 1'b1;
                end
                ST_ADDR: begin
                    state       <= ST_DATA;
                    irdy_n_out  <= 1'b0;
                    cbe_n_out   <= 4'h0;
                    frame_n_out <= cntLast;   // single-phase burst: last phase from the start
                    ad_oe       <= isWr;      // reads turn AD around immediately
                    ending      <= 1'b0;
                    endAbort    <= 1'b0;
                    devselSeen  <= 1'b0;
                    devselCnt   <= '0;
                end
                ST_DATA: if (ending) begin
                    irdy_n_out <= 1'b1;
                    state      <= ST_TURN;
                end else begin
                    if (!devsel_n)
                        devselSeen <= 1'b1;
                    else if (!devselSeen)
                        devselCnt <= devselCnt + 1'b1;
                    if (step && !isWr) begin
                        rd_data  <= ad_in;
                        rd_valid <= 1'b1;
                    end
                    if (devselTo) begin
                        frame_n_out <= 1'b1;
                        ending      <= 1'b1;
                        endAbort    <= 1'b1;
                    end else if (phaseDone && (cntLast || stopSeen)) begin
                        frame_n_out <= 1'b1;
                        irdy_n_out  <= 1'b1;
                        state       <= ST_TURN;
                    end else if (stopSeen) begin
                        // disconnect without data: drop FRAME# now, IRDY# next cycle
                        frame_n_out <= 1'b1;
                        ending      <= 1'b1;
                    end else if (step) begin
                        frame_n_out <= (remaining == LEN_W'(2));
                    end
                end
                ST_TURN: begin
                    state    <= ST_IDLE;
                    frame_oe <= 1'b0;
                    irdy_oe  <= 1'b0;
                    ad_oe    <= 1'b0;
                    cbe_oe   <= 1'b0;
                    busy     <= 1'b0;
                    if (endAbort) abort <= 1'b1;
                    else          done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_initiator.sv
// tb_pci_initiator: randomized transactions against a transaction-level target
// and arbiter model; expectations come from burst length, target behaviour
// (normal / stop with data / stop without data / no DEVSEL) and recorded data.
module tb_pci_initiator;
    import pci_pkg::*;

    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int DTO = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    cmd;
    logic [DW-1:0] addr;
    logic [LW-1:0] burst_len;
    logic [DW-1:0] wr_data;
    logic          wr_pop;
    logic [DW-1:0] rd_data;
    logic          rd_valid, busy, done, abort;
    logic [LW-1:0] xfer_cnt;
    logic          req_n, gnt_n, frame_n_in, irdy_n_in;
    logic          frame_n_out, frame_oe, irdy_n_out, irdy_oe;
    logic [DW-1:0] ad_out, ad_in;
    logic          ad_oe;
    logic [3:0]    cbe_n_out;
    logic          cbe_oe, trdy_n, devsel_n, stop_n;

    always #5 clk = ~clk;

    pci_initiator #(.DATA_W(DW), .LEN_W(LW), .DEVSEL_TIMEOUT(DTO)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
        .burst_len(burst_len), .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .abort(abort), .xfer_cnt(xfer_cnt), .req_n(req_n), .gnt_n(gnt_n),
        .frame_n_in(frame_n_in), .irdy_n_in(irdy_n_in),
        .frame_n_out(frame_n_out), .frame_oe(frame_oe),
        .irdy_n_out(irdy_n_out), .irdy_oe(irdy_oe),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
        .cbe_n_out(cbe_n_out), .cbe_oe(cbe_oe),
        .trdy_n(trdy_n), .devsel_n(devsel_n), .stop_n(stop_n)
    );

    int nVec = 0, nErr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef enum int {M_NORM, M_STOP, M_STOPNT, M_NODEV} mode_t;

    // per-transaction model state
    mode_t         mode;
    int            eff, stopAt, devDelay, gntDelay, busyLeft, waitPct, reqWait;
    int            phases, dataCyc, cyc, lastIrdy, turnLat;
    int            frameBad, oeBad, popBad, earlyAddr, doneCnt, abortCnt;
    bit            addrDue, addrSeen, busData, willComplete, targetDone, lastPop;
    bit            prevTurn, turnOk;
    logic [3:0]    txCmd;
    logic [DW-1:0] txAddr;
    logic [DW-1:0] wq[$], rdExp[$], rdGot[$];
    int            wIdx;

    task automatic idleBus();
        gnt_n = 1'b1; frame_n_in = 1'b1; irdy_n_in = 1'b1;
        trdy_n = 1'b1; devsel_n = 1'b1; stop_n = 1'b1; ad_in = '0;
    endtask

    // One bus clock: observe registered outputs, drive the next inputs, then
    // look at the combinational write handshake for the coming edge.
    task automatic stepCycle(input bit isWr, output bit fin);
        fin = 1'b0;
        @(negedge clk);
        cyc++;
        if (done)  doneCnt++;
        if (abort) abortCnt++;
        if (done || abort) begin
            fin     = 1'b1;
            turnLat = cyc - lastIrdy;
            turnOk  = prevTurn;
        end
        prevTurn = frame_oe && irdy_oe && frame_n_out && irdy_n_out;
        if (rd_valid) rdGot.push_back(rd_data);
        if (addrDue) begin
            addrDue  = 1'b0;
            addrSeen = 1'b1;
            chk("addr_frame", {frame_oe, frame_n_out, ad_oe, cbe_oe}, 4'b1011);
            chk("addr_ad", ad_out, txAddr);
            chk("addr_cbe", cbe_n_out, txCmd);
        end else if (!addrSeen && frame_oe) begin
            earlyAddr++;
        end
        busData = irdy_oe && !irdy_n_out;
        if (busData) begin
            dataCyc++;
            lastIrdy = cyc;
            if (mode == M_NORM && frame_n_out !== ((eff - phases) == 1)) frameBad++;
            if (!isWr && ad_oe) oeBad++;
        end

        // local side: stray start requests while busy must be ignored
        start = 1'b0;
        if (busy && $urandom_range(0, 9) == 0) begin
            start = 1'b1; cmd = 4'($urandom); addr = $urandom; burst_len = LW'($urandom);
        end
        if (lastPop && wIdx < wq.size() - 1) wIdx++;
        wr_data = wq[wIdx];

        // arbiter and other bus traffic
        if (!addrSeen && !addrDue) begin
            gnt_n = 1'b1; frame_n_in = 1'b1; irdy_n_in = 1'b1;
            if (!req_n) begin
                if (reqWait < gntDelay) reqWait++;
                else begin
                    gnt_n      = 1'b0;
                    frame_n_in = !(busyLeft > 1);
                    irdy_n_in  = !(busyLeft > 0);
                    if (busyLeft > 0) busyLeft--;
                    if (frame_n_in && irdy_n_in) addrDue = 1'b1;
                end
            end
        end else begin
            gnt_n      = 1'($urandom_range(0, 1));   // grant loss after ADDR is ignored
            frame_n_in = frame_oe ? frame_n_out : 1'b1;
            irdy_n_in  = irdy_oe ? irdy_n_out : 1'b1;
        end

        // target
        devsel_n = 1'b1; trdy_n = 1'b1; stop_n = 1'b1; ad_in = $urandom;
        willComplete = 1'b0;
        if (busData && mode != M_NODEV && !targetDone && dataCyc > devDelay) begin
            devsel_n = 1'b0;
            if ($urandom_range(0, 99) >= waitPct) begin
                if (mode == M_STOPNT && phases + 1 == stopAt) begin
                    stop_n = 1'b0; targetDone = 1'b1;
                end else begin
                    trdy_n = 1'b0; willComplete = 1'b1;
                    if (mode == M_STOP && phases + 1 == stopAt) begin
                        stop_n = 1'b0; targetDone = 1'b1;
                    end
                    if (phases + 1 == eff) targetDone = 1'b1;
                end
            end
        end

        #1;
        if (willComplete) begin
            if (isWr) begin
                chk("wr_pop", wr_pop, 1'b1);
                chk("wr_ad", ad_out, wq[wIdx]);
            end else begin
                rdExp.push_back(ad_in);
            end
            phases++;
        end else if (wr_pop) begin
            popBad++;
        end
        lastPop = wr_pop;
    endtask

    task automatic setupTxn(input bit isWr, input int len, input mode_t m,
                            input int stopPh, input int busyCyc);
        int b;
        mode     = m;
        eff      = (len == 0) ? 1 : len;
        stopAt   = (stopPh > 0) ? stopPh : $urandom_range(1, eff);
        devDelay = $urandom_range(0, 2);
        gntDelay = $urandom_range(0, 3);
        b        = (busyCyc >= 0) ? busyCyc : $urandom_range(0, 3);
        busyLeft = b + ((b > 0) ? 1 : 0);
        waitPct  = $urandom_range(0, 50);
        reqWait = 0; phases = 0; dataCyc = 0; cyc = 0; lastIrdy = 0; turnLat = 0;
        frameBad = 0; oeBad = 0; popBad = 0; earlyAddr = 0; doneCnt = 0; abortCnt = 0;
        addrDue = 0; addrSeen = 0; busData = 0; willComplete = 0; targetDone = 0;
        lastPop = 0; prevTurn = 0; turnOk = 0;
        wq.delete(); rdExp.delete(); rdGot.delete(); wIdx = 0;
        for (int i = 0; i < 16; i++) wq.push_back($urandom);
        if (isWr) txCmd = $urandom_range(0, 1) ? MEM_WR : IO_WR;
        else      txCmd = $urandom_range(0, 1) ? MEM_RD : IO_RD;
        txAddr    = $urandom;
        cmd       = txCmd;
        addr      = txAddr;
        burst_len = LW'(len);
        wr_data   = wq[0];
        start     = 1'b1;
    endtask

    task automatic runTxn(input bit isWr, input int len, input mode_t m,
                          input int stopPh, input int busyCyc);
        bit fin;
        int budget, expCnt;
        setupTxn(isWr, len, m, stopPh, busyCyc);
        fin = 1'b0; budget = 0;
        while (!fin && budget < 300) begin
            stepCycle(isWr, fin);
            budget++;
        end
        chk("txn_finished", fin, 1'b1);
        case (mode)
            M_NORM:   expCnt = eff;
            M_STOP:   expCnt = stopAt;
            M_STOPNT: expCnt = stopAt - 1;
            default:  expCnt = 0;
        endcase
        chk("phases", phases, expCnt);
        chk("xfer_cnt", xfer_cnt, expCnt);
        chk("done_cnt", doneCnt, (mode != M_NODEV) ? 1 : 0);
        chk("abort_cnt", abortCnt, (mode == M_NODEV) ? 1 : 0);
        chk("early_addr", earlyAddr, 0);
        chk("turn_lat", turnLat, 2);
        chk("turn_drive", turnOk, 1'b1);
        if (isWr) begin
            chk("wr_pop_stray", popBad, 0);
        end else begin
            chk("rd_cnt", rdGot.size(), rdExp.size());
            for (int i = 0; i < rdExp.size() && i < rdGot.size(); i++)
                chk("rd_data", rdGot[i], rdExp[i]);
            chk("rd_turnaround", oeBad, 0);
        end
        if (mode == M_NORM)  chk("frame_last", frameBad, 0);
        if (mode == M_NODEV) chk("abort_irdy_cycles", dataCyc, DTO + 1);
        chk("released", {busy, frame_oe, irdy_oe, ad_oe, cbe_oe, req_n}, 6'b000001);
        idleBus();
        repeat (2) @(negedge clk);
    endtask

    // Reset in the middle of a long write burst.
    task automatic rstMid();
        bit fin;
        int budget, pulses;
        setupTxn(1'b1, 8, M_NORM, 0, 0);
        waitPct = 0;
        fin = 1'b0; budget = 0;
        while (phases < 2 && budget < 100) begin
            stepCycle(1'b1, fin);
            budget++;
        end
        chk("rstmid_reached_data", phases >= 2, 1'b1);
        rst = 1'b1; start = 1'b0;
        idleBus();
        @(posedge clk); #1;
        chk("rstmid_values",
            {req_n, frame_n_out, irdy_n_out, frame_oe, irdy_oe, ad_oe, cbe_oe,
             busy, done, abort, rd_valid, wr_pop, xfer_cnt},
            {3'b111, 9'b0, 4'b0});
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || abort) pulses++;
        end
        chk("rstmid_no_pulse", pulses, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd = '0; addr = '0; burst_len = '0; wr_data = '0;
        idleBus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_values",
            {req_n, frame_n_out, irdy_n_out, frame_oe, irdy_oe, ad_oe, cbe_oe,
             busy, done, abort, rd_valid, wr_pop, xfer_cnt},
            {3'b111, 9'b0, 4'b0});
        rst = 1'b0;
        @(negedge clk);

        runTxn(1'b1, 1, M_NORM, 0, 0);     // single-phase write
        runTxn(1'b0, 4, M_NORM, 0, -1);    // four-phase read
        runTxn(1'b0, 3, M_NODEV, 0, -1);   // master abort
        runTxn(1'b1, 6, M_STOP, 2, -1);    // target stop with data on phase 2
        runTxn(1'b0, 5, M_NORM, 0, 3);     // bus busy for 3 clocks at grant
        runTxn(1'b1, 0, M_NORM, 0, -1);    // length 0 behaves as 1
        runTxn(1'b0, 15, M_NORM, 0, -1);   // maximum burst
        runTxn(1'b1, 5, M_STOPNT, 3, -1);  // disconnect without data
        rstMid();

        for (int t = 0; t < 40; t++)
            runTxn(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                   mode_t'($urandom_range(0, 3)), 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
